// File: rtl/gcd_csr_pkg.sv
// GCD accelerator CSR block: shared register offsets, bit positions
// and small types used by the APB front end and the register file.
package gcd_csr_pkg;

    localparam int unsigned ADDR_ID     = 32'h00;
    localparam int unsigned ADDR_CTRL   = 32'h04;
    localparam int unsigned ADDR_CMD    = 32'h08;
    localparam int unsigned ADDR_STATUS = 32'h0C;
    localparam int unsigned ADDR_CYCLES = 32'h10;
    localparam int unsigned ADDR_DBG0   = 32'h14;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_CT     = 1;
    localparam int CTRL_OP_LSB = 2;
    localparam int CTRL_OP_MSB = 4;

    localparam int CMD_START = 0;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_SERR = 2;
    localparam int ST_OVR  = 3;

    localparam logic [31:0] ID_DEFAULT = 32'h5A5A_5A5A;

    typedef logic [1:0] ws_t;

endpackage

// File: rtl/gcd_apb_csr_apb_slave_if.sv
// APB completer front end: access tracking, wait-state counter,
// PREADY and the setup/commit strobes for the register file.
module apb_slave_if
    import gcd_csr_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_psel,
    input  logic i_penable,
    input  logic i_pwrite,
    output logic o_pready,
    output logic o_setup,
    output logic o_wr_commit
);

    logic w_access;
    ws_t  r_cnt;

    assign w_access = i_psel & i_penable;
    assign o_setup  = i_psel & ~i_penable;

    // Counter rests at zero outside the access phase, so an abort clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!w_access) begin
            r_cnt <= '0;
        end else if (r_cnt != ws_t'(WAIT_STATES)) begin
            r_cnt <= r_cnt + ws_t'(1);
        end
    end

    generate
        if (WAIT_STATES == 0) begin : g_no_wait
            assign o_pready = 1'b1;
        end else begin : g_wait
            assign o_pready = w_access &
                              (r_cnt == ws_t'(WAIT_STATES));
        end
    endgenerate

    assign o_wr_commit = w_access & o_pready & i_pwrite;

endmodule

// File: rtl/gcd_apb_csr.sv
// APB control/status registers for the GCD core: start/busy/done
// tracking, result snapshot capture and a level interrupt.
module gcd_apb_csr
    import gcd_csr_pkg::*;
#(
    parameter int          NUM_DBG     = 5,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [ADDR_W-1:0]      PADDR,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [31:0]            PWDATA,
    input  logic [3:0]             PSTRB,
    output logic                   PREADY,
    output logic                   PSLVERR,
    output logic [31:0]            PRDATA,
    output logic                   START_PULSE,
    output logic [2:0]             OPCODE,
    output logic                   CONSTANT_TIME,
    input  logic                   DONE_PULSE,
    input  logic [11:0]            CYCLE_COUNT,
    input  logic [32*NUM_DBG-1:0]  DBG_IN,
    output logic                   IRQ
);

    localparam int IW = ADDR_W - 2;
    localparam logic [IW-1:0] I_ID   = IW'(ADDR_ID >> 2);
    localparam logic [IW-1:0] I_CTRL = IW'(ADDR_CTRL >> 2);
    localparam logic [IW-1:0] I_CMD  = IW'(ADDR_CMD >> 2);
    localparam logic [IW-1:0] I_STAT = IW'(ADDR_STATUS >> 2);
    localparam logic [IW-1:0] I_CYC  = IW'(ADDR_CYCLES >> 2);
    localparam logic [IW-1:0] I_DBG0 = IW'(ADDR_DBG0 >> 2);
    localparam logic [IW-1:0] I_LAST =
        IW'((ADDR_DBG0 >> 2) + NUM_DBG - 1);

    logic                 w_pready;
    logic                 w_setup;
    logic                 w_wr_commit;
    logic [IW-1:0]        w_idx;
    logic [IW-1:0]        w_dbg_off;
    logic                 w_ro;
    logic                 w_err;
    logic [31:0]          w_rdata;
    logic [31:0]          w_status;
    logic                 w_commit;
    logic                 w_ctrl_we;
    logic                 w_cmd;
    logic                 w_w1c;
    logic                 w_done_evt;
    logic                 w_busy_pre;
    logic                 w_start_ok;
    logic                 w_start_err;
    logic                 w_unused;

    logic [CTRL_OP_MSB:0] r_ctrl;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_serr;
    logic                 r_ovr;
    logic [11:0]          r_cycles;
    logic [31:0]          r_dbg [NUM_DBG];
    logic [31:0]          r_prdata;
    logic                 r_pslverr;
    logic                 r_start;

    apb_slave_if #(
        .WAIT_STATES (WAIT_STATES)
    ) u_apb_if (
        .i_clk       (CLK),
        .i_rst_n     (RESETn),
        .i_psel      (PSEL),
        .i_penable   (PENABLE),
        .i_pwrite    (PWRITE),
        .o_pready    (w_pready),
        .o_setup     (w_setup),
        .o_wr_commit (w_wr_commit)
    );

    assign w_idx   = PADDR[ADDR_W-1:2];
    assign w_ro    = (w_idx == I_ID) | (w_idx == I_CYC) |
                     (w_idx >= I_DBG0);
    assign w_err   = (w_idx > I_LAST) |
                     (PWRITE & w_ro) |
                     (PWRITE & (w_idx == I_CTRL) & r_busy);

    always_comb begin
        w_status          = '0;
        w_status[ST_DONE] = r_done;
        w_status[ST_BUSY] = r_busy;
        w_status[ST_SERR] = r_serr;
        w_status[ST_OVR]  = r_ovr;
    end

    always_comb begin
        w_rdata   = '0;
        w_dbg_off = w_idx - I_DBG0;
        if (w_idx == I_ID) begin
            w_rdata = ID_VALUE;
        end else if (w_idx == I_CTRL) begin
            w_rdata[CTRL_OP_MSB:0] = r_ctrl;
        end else if (w_idx == I_STAT) begin
            w_rdata = w_status;
        end else if (w_idx == I_CYC) begin
            w_rdata[11:0] = r_cycles;
        end else begin
            for (int k = 0; k < NUM_DBG; k++) begin
                if (w_idx >= I_DBG0 && w_dbg_off == IW'(k)) begin
                    w_rdata = r_dbg[k];
                end
            end
        end
    end

    // The error flag latched at setup also vetoes the commit.
    assign w_commit   = w_wr_commit & ~r_pslverr;
    assign w_ctrl_we  = w_commit & (w_idx == I_CTRL) & PSTRB[0];
    assign w_cmd      = w_commit & (w_idx == I_CMD) & PWDATA[CMD_START];
    assign w_w1c      = w_commit & (w_idx == I_STAT);

    // Completion is retired before a same-edge start is judged.
    assign w_done_evt  = DONE_PULSE & r_busy;
    assign w_busy_pre  = r_busy & ~w_done_evt;
    assign w_start_ok  = w_cmd & ~w_busy_pre;
    assign w_start_err = w_cmd & w_busy_pre;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_ctrl    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_serr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_cycles  <= '0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_start   <= 1'b0;
            for (int k = 0; k < NUM_DBG; k++) r_dbg[k] <= '0;
        end else begin
            r_start <= w_start_ok;
            r_busy  <= w_start_ok | w_busy_pre;
            r_done  <= w_done_evt |
                       (r_done & ~(w_w1c & PWDATA[ST_DONE]));
            r_serr  <= w_start_err |
                       (r_serr & ~(w_w1c & PWDATA[ST_SERR]));
            r_ovr   <= (w_done_evt & r_done) |
                       (r_ovr & ~(w_w1c & PWDATA[ST_OVR]));
            if (w_ctrl_we) r_ctrl <= PWDATA[CTRL_OP_MSB:0];
            if (w_done_evt) begin
                r_cycles <= CYCLE_COUNT;
                for (int k = 0; k < NUM_DBG; k++) begin
                    r_dbg[k] <= DBG_IN[32*k +: 32];
                end
            end
            if (w_setup) begin
                r_pslverr <= w_err;
                r_prdata  <= (w_err | PWRITE) ? '0 : w_rdata;
            end
        end
    end

    assign PREADY        = w_pready;
    assign PSLVERR       = r_pslverr;
    assign PRDATA        = r_prdata;
    assign START_PULSE   = r_start;
    assign OPCODE        = r_ctrl[CTRL_OP_MSB:CTRL_OP_LSB];
    assign CONSTANT_TIME = r_ctrl[CTRL_CT];
    assign IRQ           = r_ctrl[CTRL_IRQ_EN] &
                           (r_done | r_serr | r_ovr);

    assign w_unused = ^{PADDR[1:0], PSTRB[3:1], PWDATA[31:5]};

endmodule

// File: tb/tb_gcd_apb_csr.sv
// Bench for gcd_apb_csr: directed register scenarios plus a random
// operation mix compared against a behavioural register model.
module tb_gcd_apb_csr;

    localparam int ND = 5;
    localparam int AW = 8;
    localparam int WS = 2;
    localparam logic [31:0] IDV = 32'h5A5A_5A5A;

    logic            CLK = 1'b0;
    logic            RESETn = 1'b0;
    logic [AW-1:0]   PADDR = '0;
    logic            PSEL = 1'b0;
    logic            PENABLE = 1'b0;
    logic            PWRITE = 1'b0;
    logic [31:0]     PWDATA = '0;
    logic [3:0]      PSTRB = '0;
    logic            PREADY;
    logic            PSLVERR;
    logic [31:0]     PRDATA;
    logic            START_PULSE;
    logic [2:0]      OPCODE;
    logic            CONSTANT_TIME;
    logic            DONE_PULSE = 1'b0;
    logic [11:0]     CYCLE_COUNT = '0;
    logic [32*ND-1:0] DBG_IN = '0;
    logic            IRQ;

    int n_err = 0;
    int n_checks = 0;
    int n_start_seen = 0;

    // behavioural model of the programmer-visible state
    logic [4:0]  m_ctrl;
    logic        m_busy, m_done, m_serr, m_ovr;
    logic [11:0] m_cyc;
    logic [31:0] m_dbg [ND];
    int          m_starts;

    gcd_apb_csr #(
        .NUM_DBG     (ND),
        .ADDR_W      (AW),
        .WAIT_STATES (WS),
        .ID_VALUE    (IDV)
    ) dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .PADDR         (PADDR),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PWDATA        (PWDATA),
        .PSTRB         (PSTRB),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .PRDATA        (PRDATA),
        .START_PULSE   (START_PULSE),
        .OPCODE        (OPCODE),
        .CONSTANT_TIME (CONSTANT_TIME),
        .DONE_PULSE    (DONE_PULSE),
        .CYCLE_COUNT   (CYCLE_COUNT),
        .DBG_IN        (DBG_IN),
        .IRQ           (IRQ)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (START_PULSE === 1'b1) n_start_seen++;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_busy = 0; m_done = 0; m_serr = 0; m_ovr = 0;
        m_cyc = '0;
        for (int k = 0; k < ND; k++) m_dbg[k] = '0;
    endtask

    function automatic logic m_err(input bit wr, input logic [7:0] a);
        int idx;
        idx = int'(a[7:2]);
        if (idx > 4 + ND) return 1'b1;
        if (wr && (idx == 0 || idx == 4 || idx >= 5)) return 1'b1;
        if (wr && idx == 1 && m_busy) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int idx;
        idx = int'(a[7:2]);
        case (idx)
            0: return IDV;
            1: return {27'b0, m_ctrl};
            2: return 32'h0;
            3: return {28'b0, m_ovr, m_serr, m_busy, m_done};
            4: return {20'b0, m_cyc};
            default: begin
                if (idx >= 5 && idx < 5 + ND) return m_dbg[idx-5];
                return 32'h0;
            end
        endcase
    endfunction

    task automatic model_done();
        if (m_busy) begin
            m_busy = 0;
            if (m_done) m_ovr = 1;
            m_done = 1;
            m_cyc = CYCLE_COUNT;
            for (int k = 0; k < ND; k++) m_dbg[k] = DBG_IN[32*k +: 32];
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        case (int'(a[7:2]))
            1: if (s[0]) m_ctrl = d[4:0];
            2: if (d[0]) begin
                if (m_busy) m_serr = 1;
                else begin m_busy = 1; m_starts++; end
            end
            3: begin
                if (d[0]) m_done = 0;
                if (d[2]) m_serr = 0;
                if (d[3]) m_ovr = 0;
            end
            default: ;
        endcase
    endtask

    // One APB transfer; dp raises DONE_PULSE onto the commit edge.
    task automatic apb(input string tag, input bit wr,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit dp);
        logic e_err;
        logic [31:0] e_rd;
        bit d_evt;
        int n;
        e_err = m_err(wr, a);
        e_rd = (e_err || wr) ? 32'h0 : m_read(a);
        @(posedge CLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = a; PWRITE = wr;
        PWDATA = d; PSTRB = s;
        @(posedge CLK); #1;
        PENABLE = 1;
        n = 1;
        while (PREADY !== 1'b1 && n < 16) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(WS + 1));
        chk({tag, "_rd"}, PRDATA, e_rd);
        chk({tag, "_err"}, 32'(PSLVERR), 32'(e_err));
        if (dp) DONE_PULSE = 1;
        @(posedge CLK); #1;
        PSEL = 0; PENABLE = 0; DONE_PULSE = 0;
        d_evt = dp && m_busy;
        if (dp) model_done();
        if (wr && !e_err) model_write(a, d, s);
        if (d_evt) m_done = 1;
    endtask

    task automatic pulse_done(input logic [11:0] cc);
        @(posedge CLK); #1;
        CYCLE_COUNT = cc;
        for (int k = 0; k < ND; k++) DBG_IN[32*k +: 32] = $urandom;
        DONE_PULSE = 1;
        @(posedge CLK); #1;
        DONE_PULSE = 0;
        model_done();
    endtask

    task automatic check_outs(input string tag);
        @(posedge CLK); #1;
        chk({tag, "_op"}, 32'(OPCODE), 32'(m_ctrl[4:2]));
        chk({tag, "_ct"}, 32'(CONSTANT_TIME), 32'(m_ctrl[1]));
        chk({tag, "_irq"}, 32'(IRQ),
            32'(m_ctrl[0] & (m_done | m_serr | m_ovr)));
        chk({tag, "_starts"}, 32'(n_start_seen), 32'(m_starts));
    endtask

    initial begin
        logic [7:0] ra;
        int op;
        model_reset();
        m_starts = 0;
        #12;
        chk("rst_pready", 32'(PREADY), 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_start", 32'(START_PULSE), 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("rst_op", 32'(OPCODE), 32'h0);
        chk("rst_ct", 32'(CONSTANT_TIME), 32'h0);
        @(posedge CLK); #1;
        RESETn = 1;

        apb("rd_id", 0, 8'h00, 0, 4'hF, 0);
        apb("rd_stat0", 0, 8'h0C, 0, 4'hF, 0);
        apb("ctrl_nostrb", 1, 8'h04, 32'hFFFF_FFFF, 4'b1110, 0);
        apb("rd_ctrl0", 0, 8'h04, 0, 4'hF, 0);
        apb("wr_ctrl", 1, 8'h04, 32'h0000_000D, 4'b0001, 0);
        apb("rd_ctrl", 0, 8'h04, 0, 4'hF, 0);
        chk("ctrl_op3", 32'(OPCODE), 32'd3);
        apb("cmd1", 1, 8'h08, 32'h1, 4'hF, 0);
        check_outs("cmd1");
        apb("rd_busy", 0, 8'h0C, 0, 4'hF, 0);
        @(posedge CLK); #1;
        CYCLE_COUNT = 12'h07B;
        DBG_IN[31:0] = 32'hCAFE_F00D;
        DONE_PULSE = 1;
        @(posedge CLK); #1;
        DONE_PULSE = 0;
        model_done();
        check_outs("done1");
        chk("done1_irq1", 32'(IRQ), 32'h1);
        apb("rd_stat1", 0, 8'h0C, 0, 4'hF, 0);
        apb("rd_cyc", 0, 8'h10, 0, 4'hF, 0);
        apb("rd_dbg0", 0, 8'h14, 0, 4'hF, 0);
        for (int k = 1; k < ND; k++)
            apb("rd_dbgk", 0, 8'(8'h14 + 4 * k), 0, 4'hF, 0);

        apb("w1c_done", 1, 8'h0C, 32'h1, 4'hF, 0);
        check_outs("w1c");
        apb("cmd2", 1, 8'h08, 32'h1, 4'hF, 0);
        apb("w1c_race", 1, 8'h0C, 32'h1, 4'hF, 1);
        apb("rd_race", 0, 8'h0C, 0, 4'hF, 0);
        check_outs("race");

        apb("cmd3", 1, 8'h08, 32'h1, 4'hF, 0);
        apb("cmd_busy", 1, 8'h08, 32'h1, 4'hF, 0);
        check_outs("cmd_busy");
        apb("ctrl_busy", 1, 8'h04, 32'h0000_001C, 4'hF, 0);
        apb("rd_ctrl_b", 0, 8'h04, 0, 4'hF, 0);
        apb("rd_oor", 0, 8'(8'h14 + 4 * ND), 0, 4'hF, 0);
        apb("wr_cyc", 1, 8'h10, 32'hFFF, 4'hF, 0);
        apb("wr_id", 1, 8'h00, 32'h1234, 4'hF, 0);
        apb("rd_cyc_b", 0, 8'h10, 0, 4'hF, 0);
        apb("rd_stat_b", 0, 8'h0C, 0, 4'hF, 0);

        pulse_done(12'h321);
        apb("w1c_all", 1, 8'h0C, 32'hF, 4'hF, 0);
        apb("cmd_o1", 1, 8'h08, 32'h1, 4'hF, 0);
        pulse_done(12'h011);
        apb("cmd_o2", 1, 8'h08, 32'h1, 4'hF, 0);
        pulse_done(12'h022);
        apb("rd_ovr", 0, 8'h0C, 0, 4'hF, 0);
        check_outs("ovr");

        // aborted CTRL write must not land
        @(posedge CLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = 8'h04; PWRITE = 1;
        PWDATA = 32'h1F; PSTRB = 4'hF;
        @(posedge CLK); #1;
        PENABLE = 1;
        @(posedge CLK); #1;
        PSEL = 0; PENABLE = 0;
        apb("rd_abort", 0, 8'h04, 0, 4'hF, 0);

        apb("cmd_c", 1, 8'h08, 32'h1, 4'hF, 0);
        apb("cmd_done_same", 1, 8'h08, 32'h1, 4'hF, 1);
        check_outs("cmd_done_same");
        apb("rd_same", 0, 8'h0C, 0, 4'hF, 0);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            ra = 8'($urandom_range(0, 47));
            case (op)
                0: apb("r_ctrl", 1, 8'h04, $urandom,
                       4'($urandom_range(0, 15)), 0);
                1: apb("r_cmd", 1, 8'h08, $urandom, 4'hF,
                       1'($urandom_range(0, 1)));
                2: pulse_done(12'($urandom));
                3: apb("r_w1c", 1, 8'h0C, $urandom, 4'hF,
                       1'($urandom_range(0, 1)));
                4: apb("r_rd", 0, ra, 0, 4'hF, 0);
                default: apb("r_wr", 1, ra, $urandom, 4'hF, 0);
            endcase
            check_outs("rnd");
        end

        // set up a live operation with IRQ high, then reset mid-access
        pulse_done(12'h001);
        apb("pre_ctrl", 1, 8'h04, 32'h1F, 4'hF, 0);
        apb("pre_cmd", 1, 8'h08, 32'h1, 4'hF, 0);
        pulse_done(12'h0AA);
        apb("pre_cmd2", 1, 8'h08, 32'h1, 4'hF, 0);
        check_outs("pre_rst");
        @(posedge CLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = 8'h00; PWRITE = 0;
        @(posedge CLK); #1;
        PENABLE = 1;
        #2;
        RESETn = 0;
        #1;
        chk("mrst_pready", 32'(PREADY), 32'h0);
        chk("mrst_prdata", PRDATA, 32'h0);
        chk("mrst_pslverr", 32'(PSLVERR), 32'h0);
        chk("mrst_start", 32'(START_PULSE), 32'h0);
        chk("mrst_irq", 32'(IRQ), 32'h0);
        chk("mrst_op", 32'(OPCODE), 32'h0);
        chk("mrst_ct", 32'(CONSTANT_TIME), 32'h0);
        PSEL = 0; PENABLE = 0;
        model_reset();
        @(posedge CLK); #1;
        RESETn = 1;
        pulse_done(12'h5A5);
        apb("post_stat", 0, 8'h0C, 0, 4'hF, 0);
        apb("post_cyc", 0, 8'h10, 0, 4'hF, 0);
        check_outs("post");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gcd_apb_csr.md
# gcd_apb_csr

Parametrised APB control/status register block for the GCD accelerator wrapper. It sits between the system APB bus and the GCD core. It generates the start pulse and opcode/mode controls, and tracks busy and done state. On completion it captures the cycle count and a configurable number of 32-bit debug words. It provides configurable wait states, byte strobes, error responses, sticky W1C status and an interrupt.

## Interface
Parameters:
- NUM_DBG, 5: number of 32-bit debug snapshot registers (1..16).
- ADDR_W, 8: PADDR width; must hold 0x14 + 4*NUM_DBG.
- WAIT_STATES, 0: access-phase wait cycles before PREADY (0..3).
- ID_VALUE, 32'h5A5A_5A5A: ID register contents.

Ports:
- CLK  in  1  clock. One clock; reset is asynchronous and active-low.
- RESETn  in  1  asynchronous active-low reset.
- PADDR  in  ADDR_W  byte address; [1:0] ignored.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte strobes; honoured by CTRL only.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error, valid with PREADY.
- PRDATA  out  32  read data, valid with PREADY.
- START_PULSE  out  1  one-cycle start to core.
- OPCODE  out  3  CTRL[4:2].
- CONSTANT_TIME  out  1  CTRL[1].
- DONE_PULSE  in  1  one-cycle completion from core.
- CYCLE_COUNT  in  12  core cycle counter.
- DBG_IN  in  32*NUM_DBG  debug words; word k is [32k+31:32k].
- IRQ  out  1  level interrupt.

## Operation
- Map:
  - 0x00 ID, read-only.
  - 0x04 CTRL, read/write: [0] IRQ_EN, [1] CONSTANT_TIME, [4:2] OPCODE; other bits read 0.
  - 0x08 CMD, write-only, reads 0: bit0=1 requests start.
  - 0x0C STATUS: [0] DONE W1C, [1] BUSY read-only, [2] START_ERR W1C, [3] OVERRUN W1C.
  - 0x10 CYCLES, read-only: [11:0] latched CYCLE_COUNT.
  - 0x14+4k DBGk, read-only.
- PSLVERR=1, with no state change, for:
  - any address beyond the last DBG register;
  - writes to a read-only register;
  - CTRL writes while BUSY=1.
- Error reads return 0.
- CMD start with BUSY=0: START_PULSE fires and BUSY sets. CMD start with BUSY=1: START_ERR sets, no pulse.
- DONE_PULSE with BUSY=1:
  - BUSY clears and DONE sets;
  - CYCLES and every DBGk capture their inputs;
  - if DONE was already 1, OVERRUN also sets.
- DONE_PULSE with BUSY=0 is ignored.
- IRQ = IRQ_EN & (DONE | START_ERR | OVERRUN).
- Reset values:
  - all registers 0; PRDATA 0, PSLVERR 0, START_PULSE 0, IRQ 0, OPCODE 0, CONSTANT_TIME 0;
  - PREADY 1 when WAIT_STATES=0, else 0.

## Timing
- Setup phase: PSEL=1, PENABLE=0. Access phase: PSEL=1, PENABLE=1.
- Wait-state counter clears in setup. PREADY asserts in the access cycle where the counter equals WAIT_STATES, so access lasts WAIT_STATES+1 cycles.
- WAIT_STATES=0: PREADY is tied 1.
- Commit happens at PSEL&PENABLE&PREADY only. Register writes and W1C take effect on that edge.
- PRDATA and PSLVERR are registered, loaded at the setup edge, and held until the next setup.
- START_PULSE is high for exactly the one cycle after the CMD commit edge. BUSY reads 1 from that same cycle.
- DONE_PULSE sets take effect one edge later. A STATUS read committing on that edge returns the pre-update value.
- Simultaneous DONE set and W1C clear of DONE: the set wins. The same rule applies to START_ERR and OVERRUN.
- CMD commit on the same edge as DONE_PULSE: done is processed first. BUSY=0 is then seen, so the start is accepted and BUSY stays 1.
- PSEL dropped mid-access: the transfer is aborted, no commit, counter cleared.
- RESETn asserted mid-transfer or mid-operation: everything returns to reset values immediately. A later DONE_PULSE is ignored because BUSY=0.

## Structure
- Package gcd_csr_pkg:
  - offsets ADDR_ID..ADDR_DBG0;
  - CTRL and STATUS bit positions;
  - default ID constant;
  - WAIT_STATES width type.
- Sub-module apb_slave_if:
  - setup/access tracking and the wait-state counter;
  - PREADY generation;
  - wr_commit and rd_setup strobes.
- The register and decode logic stays in gcd_apb_csr.

## Test plan
- Reset, then read 0x00 and 0x0C, with WAIT_STATES=2 → ID_VALUE and 0. Each access shows PREADY after 3 access cycles. PSLVERR=0.
- Write CTRL=0x0000_000D with PSTRB=4'b0001, then CMD=1 → OPCODE=3, IRQ_EN=1, one START_PULSE, STATUS=0x2. DONE_PULSE with CYCLE_COUNT=12'h07B and DBG_IN[0]=0xCAFE_F00D → STATUS=0x1, CYCLES=0x07B, DBG0=0xCAFE_F00D, IRQ=1.
- Write STATUS=0x1 → DONE clears and IRQ drops. Repeat with DONE_PULSE on the commit edge → DONE stays 1.
- CMD while BUSY → no pulse, START_ERR=1. CTRL write while BUSY → PSLVERR=1, CTRL unchanged.
- Read 0x14+4*NUM_DBG and write 0x10 → PSLVERR=1, PRDATA=0, no state change.
- Two done cycles without clearing DONE → OVERRUN=1. Assert RESETn low mid-access → all outputs at reset values, and a following DONE_PULSE is ignored.
